// File: rtl/rgbw_pkg.sv
// Shared definitions for the RGBW PWM bank: default widths, channel indices,
// commit FSM states and the phase-stagger offset helper.
package rgbw_pkg;

    localparam int NUM_CH_DEF  = 4;
    localparam int DUTY_W_DEF  = 8;
    localparam int PRESC_W_DEF = 8;
    localparam int ADDR_W_DEF  = 4;

    localparam int CH_RED   = 0;
    localparam int CH_GREEN = 1;
    localparam int CH_BLUE  = 2;
    localparam int CH_WHITE = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } commit_state_t;

    // Counter offset for channel ch when edges are spread evenly over one period.
    function automatic int phase_offset(input int ch, input int num_ch, input int duty_w);
        return (ch * ((1 << duty_w) / num_ch)) % (1 << duty_w);
    endfunction

endpackage

// File: rtl/rgbw_pwm_bank_if.sv
// Duty write / commit port between the SPI deserializer (master) and the PWM bank (slave).
interface rgbw_pwm_bank_if
    import rgbw_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DUTY_W = DUTY_W_DEF
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DUTY_W-1:0] wr_data;
    logic              commit;
    logic              commit_pending;
    logic              upd_done;

    modport master (
        output wr_en, wr_addr, wr_data, commit,
        input  commit_pending, upd_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit,
        output commit_pending, upd_done
    );
endinterface

// File: rtl/rgbw_tick_presc.sv
// Runtime-programmable tick divider: one tick every presc cycles (0 and 1 mean every cycle).
module rgbw_tick_presc
    import rgbw_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);
    logic [PRESC_W-1:0] pcnt_reg;
    logic [PRESC_W-1:0] pcnt_next;
    logic               last_cnt;

    // The >= compare lets a shrinking presc terminate the count instead of wrapping.
    always_comb begin
        last_cnt  = (presc <= PRESC_W'(1)) || (pcnt_reg >= (presc - PRESC_W'(1)));
        tick      = en && last_cnt;
        pcnt_next = (!en || last_cnt) ? '0 : pcnt_reg + PRESC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_reg <= '0;
        end else begin
            pcnt_reg <= pcnt_next;
        end
    end

endmodule

// File: rtl/rgbw_pwm_bank.sv
// N-channel PWM bank with shadow duty registers committed atomically at the period wrap.
// Optional macro PWM_PHASE_STAGGER_EN spreads channel rising edges evenly across the period.
module rgbw_pwm_bank
    import rgbw_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int DUTY_W  = DUTY_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    rgbw_pwm_bank_if.slave     bus,
    output logic               period_start,
    output logic [NUM_CH-1:0]  pwm_out
);
    logic              tick;
    logic              wrap;
    logic [DUTY_W-1:0] cnt_reg;
    logic              period_start_reg;
    logic              upd_done_reg;
    logic              load_active;
    commit_state_t     state_reg;
    commit_state_t     state_next;

    rgbw_tick_presc #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .presc (presc),
        .tick  (tick)
    );

    assign wrap = tick && (cnt_reg == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg          <= '0;
            period_start_reg <= 1'b0;
            upd_done_reg     <= 1'b0;
            state_reg        <= ST_IDLE;
        end else begin
            if (!en) begin
                cnt_reg <= '0;
            end else if (tick) begin
                cnt_reg <= cnt_reg + DUTY_W'(1);
            end
            period_start_reg <= wrap;
            upd_done_reg     <= load_active;
            state_reg        <= state_next;
        end
    end

    // A commit arriving in IDLE on a wrap cycle waits for the following wrap.
    always_comb begin
        state_next  = state_reg;
        load_active = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.commit) begin
                    state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (wrap) begin
                    load_active = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.commit_pending = (state_reg == ST_PENDING);
    assign bus.upd_done       = upd_done_reg;
    assign period_start       = period_start_reg;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
`ifdef PWM_PHASE_STAGGER_EN
        localparam logic [DUTY_W-1:0] PHASE_OFF = DUTY_W'(phase_offset(gi, NUM_CH, DUTY_W));
`else
        localparam logic [DUTY_W-1:0] PHASE_OFF = '0;
`endif
        logic [DUTY_W-1:0] shadow_reg;
        logic [DUTY_W-1:0] active_reg;
        logic [DUTY_W-1:0] cmp_val;
        logic              pwm_bit_reg;

        assign cmp_val    = cnt_reg + PHASE_OFF;
        assign pwm_out[gi] = pwm_bit_reg;

        // Out-of-range addresses match no channel, so such writes simply vanish.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_reg  <= '0;
                active_reg  <= '0;
                pwm_bit_reg <= 1'b0;
            end else begin
                if (load_active) begin
                    active_reg <= shadow_reg;
                end
                if (bus.wr_en && (bus.wr_addr == ADDR_W'(gi))) begin
                    shadow_reg <= bus.wr_data;
                end
                pwm_bit_reg <= en && (cmp_val < active_reg);
            end
        end
    end

endmodule
